// File: rtl/router_pkg.sv
// Shared constants, bank index type and wrap helper for the data-router bank selector.
package router_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned NBANK = 3;
  localparam int unsigned BUFW  = 32;
  localparam int unsigned BW    = $clog2(NBANK);

  typedef logic [BW-1:0] bank_idx_t;

  // Wrapped increment of a bank index over nbank banks.
  function automatic int unsigned next_bank(input int unsigned idx, input int unsigned nbank);
    return (idx >= nbank - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bank_router_ptr.sv
// Rotating bank pointer: load (clamped to a valid bank) takes priority over advance,
// and a load with advance in the same cycle steps past the loaded value.
module bank_router_ptr #(
  parameter int unsigned NBANK = router_pkg::NBANK,
  localparam int unsigned BW = $clog2(NBANK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [BW-1:0] load_val,
  output logic [BW-1:0] ptr
);
  import router_pkg::*;

  logic [BW-1:0] base;
  logic [BW-1:0] ptr_next;

  always_comb begin
    base     = ptr;
    ptr_next = ptr;
    if (load) begin
      base = (32'(load_val) < NBANK) ? load_val : '0;
    end
    ptr_next = base;
    if (advance) begin
      ptr_next = BW'(next_bank(32'(base), NBANK));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/bank_router.sv
// One-stage valid/ready bank selector: routes one of NBANK line-buffer rows to the PE feed.
// Optional internal rotating bank pointer enabled by defining BANK_ROUTER_ROTATE_EN.
module bank_router #(
  parameter int unsigned DW    = router_pkg::DW,
  parameter int unsigned NBANK = router_pkg::NBANK,
  parameter int unsigned BUFW  = router_pkg::BUFW,
  localparam int unsigned BW   = $clog2(NBANK)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NBANK-1:0][BUFW-1:0][DW-1:0]    idata,
  input  logic [BW-1:0]                         bank_sel,
  input  logic                                  rot_en,
  input  logic                                  rot_load,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BUFW-1:0][DW-1:0]               odata,
  output logic [BW-1:0]                         obank,
  output logic                                  err
);

  logic          acc;
  logic [BW-1:0] eff;
  logic          in_range;

  // Output register may drain and refill in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

`ifdef BANK_ROUTER_ROTATE_EN
  logic [BW-1:0] rot_ptr;

  bank_router_ptr #(
    .NBANK(NBANK)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (rot_load),
    .advance  (acc && rot_en),
    .load_val (bank_sel),
    .ptr      (rot_ptr)
  );

  // A load in the same cycle as a rotated beat routes that beat from bank_sel.
  assign eff = (rot_en && !rot_load) ? rot_ptr : bank_sel;
`else
  logic unused_rot;
  assign unused_rot = rot_en ^ rot_load;
  assign eff        = bank_sel;
`endif

  assign in_range = 32'(eff) < NBANK;

  // Out-of-range beats are still delivered, with zero data and err flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      odata     <= '0;
      obank     <= '0;
      err       <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      obank     <= eff;
      err       <= !in_range;
      odata     <= in_range ? idata[eff] : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
